// File: rtl/divideu.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones quotient with div0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results from the last division are held
// RUN    | one restoring-division step per cycle, L1 cycles in total
// DONE   | results valid, done pulses for this single cycle
module divideu #(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [L1-1:0] in1,
  input  logic [L2-1:0] in2,
  output logic          busy,
  output logic          done,
  output logic [L1-1:0] quot,
  output logic [L2-1:0] rem,
  output logic          div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(L1 + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [L1-1:0] dvd_q,   dvd_d;
  logic [L2-1:0] dvs_q,   dvs_d;
  logic [L2-1:0] prem_q,  prem_d;
  logic [L1-1:0] quot_q,  quot_d;
  logic [L2-1:0] rem_q,   rem_d;
  logic          div0_q,  div0_d;

  logic [L2:0]   shifted;
  logic [L2:0]   diff;
  logic          ge;
  logic [L2-1:0] step_rem;
  logic [L1-1:0] step_quo;

  // dvd_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
  // The partial remainder is always below the divisor, so after the shift it needs
  // one extra bit and the subtraction result fits back into L2 bits.
  always_comb begin
    shifted  = {prem_q, dvd_q[L1-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = (shifted >= {1'b0, dvs_q});
    step_rem = ge ? diff[L2-1:0] : shifted[L2-1:0];
    step_quo = (dvd_q << 1) | L1'(ge);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d  = in1;
          dvs_d  = in2;
          prem_d = '0;
          rem_d  = '0;
          if (in2 == '0) begin
            quot_d  = '1;
            div0_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            quot_d  = '0;
            div0_d  = 1'b0;
            cnt_d   = CW'(L1);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        dvd_d  = step_quo;
        prem_d = step_rem;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = step_quo;
          rem_d   = step_rem;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign quot = quot_q;
  assign rem  = rem_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_divideu.sv
// Bench for divideu (L1=L2=8): directed scenarios plus a random sweep, with
// results checked by a queue-based scoreboard against plain integer arithmetic.
module tb_divideu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic       busy, done, div0;
  logic [7:0] quot, rem;

  divideu #(.L1(8), .L2(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int d0;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ncyc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Monitor: counts cycles at the falling edge and compares every done pulse.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", int'(quot), e.q);
        chk("rem", int'(rem), e.r);
        chk("div0", int'(div0), e.d0);
        chk("latency", ncyc, e.due);
      end
    end else if (sb.size() > 0 && ncyc > sb[0].due) begin
      chk("missing_done", ncyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // Drive one accepted start; returns one tick after the accept edge.
  task automatic issue(input int a, input int b);
    exp_t e;
    @(negedge clk);
    #1;
    start = 1'b1;
    in1   = 8'(a);
    in2   = 8'(b);
    if (b == 0) begin
      e.q = 255; e.r = 0; e.d0 = 1; e.due = ncyc + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.d0 = 0; e.due = ncyc + 9;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = 8'($urandom);
    in2   = 8'($urandom);
  endtask

  // Waits for done (bounded), reporting cycles since accept and busy cycles seen.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_hold(input int q, input int r, input int d0);
    repeat (3) @(negedge clk);
    chk("hold_quot", int'(quot), q);
    chk("hold_rem", int'(rem), r);
    chk("hold_div0", int'(div0), d0);
    chk("hold_busy", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, a, b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_div0", int'(div0), 0);
    #1 rst = 1'b0;

    // 200/7: eight busy cycles, done in cycle 9
    issue(200, 7);
    wait_done(cyc, bc);
    chk("lat_200_7", cyc, 9);
    chk("busy_200_7", bc, 8);
    check_hold(28, 4, 0);

    issue(255, 1);
    wait_done(cyc, bc);
    issue(5, 9);
    wait_done(cyc, bc);
    check_hold(0, 5, 0);

    // Zero divisor: done in cycle 1, busy never asserted
    issue(77, 0);
    wait_done(cyc, bc);
    chk("lat_div0", cyc, 1);
    chk("busy_div0", bc, 0);
    check_hold(255, 0, 1);

    // Stray starts in RUN cycle 3 and in DONE must be ignored
    issue(200, 7);
    repeat (2) @(negedge clk);
    @(negedge clk);
    #1 start = 1'b1; in1 = 8'd1; in2 = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        bc = 1;
        break;
      end
    end
    chk("stray_done_seen", bc, 1);
    #1 start = 1'b1; in1 = 8'd3; in2 = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    chk("stray_quot", int'(quot), 28);
    chk("stray_rem", int'(rem), 4);
    chk("stray_busy", int'(busy), 0);

    // Reset during RUN cycle 4 aborts without a done pulse
    issue(200, 7);
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quot), 0);
    chk("abort_rem", int'(rem), 0);
    chk("abort_div0", int'(div0), 0);
    repeat (12) @(negedge clk);
    issue(100, 10);
    wait_done(cyc, bc);
    check_hold(10, 0, 0);

    // Random sweep, back-to-back on the first IDLE cycle after done
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      if (i % 10 == 0) b = 255;
      if (i % 10 == 1) a = 0;
      if (i % 50 == 2) b = 0;
      issue(a, b);
      wait_done(cyc, bc);
    end

    repeat (12) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
